// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline: skid-stage state encoding and an
// occupancy helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // Number of words a stage holds in a given state.
  function automatic logic [1:0] occ(input skid_state_t s);
    case (s)
      ST_BUSY: occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One skid-buffer stage: main register M feeds downstream, skid register S
// catches the word accepted in the cycle downstream stalls.
module skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  skid_state_t      state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             acc, tx;
  logic             load_main_up, load_main_skid, load_skid_up;

  // Ready decodes only the state register, so no combinational path crosses
  // the stage from dn_ready to up_ready.
  assign up_ready = (state != ST_FULL);
  assign dn_valid = (state != ST_EMPTY);
  assign dn_data  = main_q;

  assign acc = up_valid & up_ready;
  assign tx  = dn_valid & dn_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt      = state;
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_up   = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nxt    = ST_BUSY;
          load_main_up = 1'b1;
        end
      end
      ST_BUSY: begin
        if (acc && !tx) begin
          state_nxt    = ST_FULL;
          load_skid_up = 1'b1;
        end else if (acc && tx) begin
          load_main_up = 1'b1;
        end else if (tx) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (tx) begin
          state_nxt      = ST_BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: data registers are reset here so out_data shows RESET_VAL after
      // reset; flush below clears only the state and leaves data as is.
      state  <= ST_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
      if (load_main_up)        main_q <= up_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_up)        skid_q <= up_data;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic pipeline register: DEPTH chained skid stages under valid/ready,
// with synchronous flush and a registered occupancy count.
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  // Index i is the interface feeding stage i; index DEPTH is the output.
  logic             valid_c [DEPTH+1];
  logic             ready_c [DEPTH+1];
  logic [WIDTH-1:0] data_c  [DEPTH+1];
  logic             in_xfer, out_xfer;

  assign valid_c[0]     = in_valid;
  assign data_c[0]      = in_data;
  assign in_ready       = ready_c[0];
  assign out_valid      = valid_c[DEPTH];
  assign out_data       = data_c[DEPTH];
  assign ready_c[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    skid_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .up_valid(valid_c[i]),
      .up_ready(ready_c[i]),
      .up_data (data_c[i]),
      .dn_valid(valid_c[i+1]),
      .dn_ready(ready_c[i+1]),
      .dn_data (data_c[i+1])
    );
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Tracks the sum of stage occupancies; flush voids both handshakes.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe: three instances (DEPTH 2, 1, 5) at WIDTH 8
// sharing clock, reset and flush.
module tb_elastic_pipe;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'h5A;
  localparam int         NI = 3;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic       in_valid_a  [NI];
  logic       in_ready_a  [NI];
  logic       out_valid_a [NI];
  logic       out_ready_a [NI];
  logic [7:0] in_data_a   [NI];
  logic [7:0] out_data_a  [NI];
  logic [7:0] count_a     [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    localparam int CW = $clog2(2*D+1);
    logic          rdy, vld;
    logic [7:0]    od;
    logic [CW-1:0] cnt;

    elastic_pipe #(
      .WIDTH    (W),
      .DEPTH    (D),
      .RESET_VAL(RV)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid_a[g]),
      .in_ready (rdy),
      .in_data  (in_data_a[g]),
      .out_valid(vld),
      .out_ready(out_ready_a[g]),
      .out_data (od),
      .count    (cnt)
    );

    assign in_ready_a[g]  = rdy;
    assign out_valid_a[g] = vld;
    assign out_data_a[g]  = od;
    assign count_a[g]     = 8'(cnt);
  end

  function automatic int depth_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      in_valid_a[k]  = 1'b0;
      in_data_a[k]   = 8'h00;
      out_ready_a[k] = 1'b0;
    end
    flush = 1'b0;
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < NI; k++) begin
      in_valid_a[k]  = 1'($urandom_range(0, 1));
      in_data_a[k]   = 8'($urandom);
      out_ready_a[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_d%0d_out_valid", tag, depth_of(k)), out_valid_a[k], 1'b0);
      check($sformatf("%s_d%0d_in_ready", tag, depth_of(k)), in_ready_a[k], 1'b1);
      check($sformatf("%s_d%0d_count", tag, depth_of(k)), count_a[k], 0);
      check($sformatf("%s_d%0d_out_data", tag, depth_of(k)), out_data_a[k], RV);
    end
  endtask

  // Push 0x01..0x10 back to back with out_ready=1; word j must appear in
  // cycle (j-1)+DEPTH, one per cycle.
  task automatic test_stream(input int k);
    int   d = depth_of(k);
    int   got_n = 0;
    logic exp_v;
    out_ready_a[k] = 1'b1;
    for (int cyc = 0; cyc < 16 + d + 4; cyc++) begin
      exp_v = (cyc >= d) && (cyc < d + 16);
      check($sformatf("stream_d%0d_valid_c%0d", d, cyc), out_valid_a[k], exp_v);
      if (out_valid_a[k]) begin
        check($sformatf("stream_d%0d_data_c%0d", d, cyc), out_data_a[k], cyc - d + 1);
        got_n++;
      end
      if (cyc < 16) begin
        check($sformatf("stream_d%0d_in_ready_c%0d", d, cyc), in_ready_a[k], 1'b1);
        in_valid_a[k] = 1'b1;
        in_data_a[k]  = 8'(cyc + 1);
      end else begin
        in_valid_a[k] = 1'b0;
      end
      step();
    end
    check($sformatf("stream_d%0d_received", d), got_n, 16);
    check($sformatf("stream_d%0d_count_end", d), count_a[k], 0);
    idle_all();
  endtask

  // Fill with out_ready=0 until 2*DEPTH words are held; returns words accepted.
  task automatic fill_stalled(input int k, input logic [7:0] base, output int acc);
    int d = depth_of(k);
    acc = 0;
    out_ready_a[k] = 1'b0;
    for (int cyc = 0; cyc < 2*d + 4; cyc++) begin
      in_valid_a[k] = 1'b1;
      in_data_a[k]  = base + 8'(acc);
      if (in_ready_a[k]) acc++;
      step();
    end
    in_valid_a[k] = 1'b0;
  endtask

  task automatic test_stall(input int k);
    int d = depth_of(k);
    int acc;
    int first_rdy = -1;
    fill_stalled(k, 8'hA0, acc);
    check($sformatf("stall_d%0d_accepted", d), acc, 2*d);
    check($sformatf("stall_d%0d_in_ready", d), in_ready_a[k], 1'b0);
    check($sformatf("stall_d%0d_count", d), count_a[k], 2*d);
    check($sformatf("stall_d%0d_head_valid", d), out_valid_a[k], 1'b1);
    check($sformatf("stall_d%0d_head_data", d), out_data_a[k], 8'hA0);
    out_ready_a[k] = 1'b1;
    for (int i = 0; i < 2*d; i++) begin
      if (first_rdy < 0 && in_ready_a[k]) first_rdy = i;
      check($sformatf("drain_d%0d_valid_%0d", d, i), out_valid_a[k], 1'b1);
      check($sformatf("drain_d%0d_data_%0d", d, i), out_data_a[k], 8'hA0 + 8'(i));
      check($sformatf("drain_d%0d_count_%0d", d, i), count_a[k], 2*d - i);
      step();
    end
    if (first_rdy < 0 && in_ready_a[k]) first_rdy = 2*d;
    check($sformatf("release_d%0d_ready_in_time", d), (first_rdy >= 0) && (first_rdy <= d), 1'b1);
    check($sformatf("drain_d%0d_count_end", d), count_a[k], 0);
    check($sformatf("drain_d%0d_valid_end", d), out_valid_a[k], 1'b0);
    idle_all();
  endtask

  // 10k cycles of random handshakes against a FIFO scoreboard.
  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] nw = 8'h00;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       iv, orr;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rnd_count", count_a[0], q.size());
      if (prev_stall) begin
        check("rnd_stall_valid", out_valid_a[0], 1'b1);
        check("rnd_stall_data", out_data_a[0], prev_data);
      end
      iv  = 1'($urandom_range(0, 1));
      orr = 1'($urandom_range(0, 1));
      in_valid_a[0]  = iv;
      in_data_a[0]   = iv ? nw : 8'($urandom);
      out_ready_a[0] = orr;
      if (out_valid_a[0] && orr) begin
        if (q.size() == 0) check("rnd_spurious_word", out_data_a[0], 32'hFFFF_FFFF);
        else               check("rnd_data", out_data_a[0], q.pop_front());
      end
      if (iv && in_ready_a[0]) begin
        q.push_back(nw);
        nw++;
      end
      prev_stall = out_valid_a[0] && !orr;
      prev_data  = out_data_a[0];
      step();
    end
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid_a[0]) begin
        if (q.size() == 0) check("rnd_drain_spurious", out_data_a[0], 32'hFFFF_FFFF);
        else               check("rnd_drain_data", out_data_a[0], q.pop_front());
      end
      step();
    end
    check("rnd_scoreboard_empty", q.size(), 0);
    check("rnd_count_end", count_a[0], 0);
    idle_all();
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready_a[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[0] = 1'b1;
      in_data_a[0]  = 8'hC0 + 8'(i);
      step();
    end
    check("flush_pre_count", count_a[0], 3);
    flush          = 1'b1;
    in_valid_a[0]  = 1'b1;
    in_data_a[0]   = 8'hEE;
    out_ready_a[0] = 1'b1;
    step();
    flush         = 1'b0;
    in_valid_a[0] = 1'b0;
    check("flush_count", count_a[0], 0);
    check("flush_out_valid", out_valid_a[0], 1'b0);
    check("flush_in_ready", in_ready_a[0], 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("flush_quiet_%0d", i), out_valid_a[0], 1'b0);
      step();
    end
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = 8'h33;
    step();
    in_valid_a[0] = 1'b0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (out_valid_a[0]) begin
        check("flush_next_word", out_data_a[0], 8'h33);
        seen = 1;
      end
      step();
    end
    check("flush_next_seen", seen, 1);
    check("flush_after_count", count_a[0], 0);
    idle_all();
  endtask

  task automatic test_reset_mid();
    int acc;
    fill_stalled(0, 8'h70, acc);
    check("rmid_full_count", count_a[0], 4);
    reset = 1'b1;
    flush = 1'b1;
    randomize_inputs();
    step();
    randomize_inputs();
    step();
    reset = 1'b0;
    idle_all();
    check_reset_state("rmid");
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    randomize_inputs();
    flush = 1'($urandom_range(0, 1));
    step();
    randomize_inputs();
    step();
    reset = 1'b0;
    idle_all();
    check_reset_state("reset");

    test_stream(0);
    test_stall(0);
    test_random();
    test_flush();
    test_reset_mid();
    test_stream(1);
    test_stall(1);
    test_stream(2);
    test_stall(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
